// File: rtl/shuttle_scheduler.sv
// Two-stop shuttle sequencer: queues arrivals per stop and issues BOARD / DRIVE / ALIGHT
// commands over a valid/ready/done handshake, with a step_tick watchdog on each command.
module shuttle_scheduler #(
  parameter int unsigned MAX_WAIT      = 2,
  parameter int unsigned TIMEOUT_TICKS = 12
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_step_tick,
  input  logic       i_arrive_b1,
  input  logic       i_arrive_b2,
  output logic       o_cmd_valid,
  output logic [1:0] o_cmd_op,
  output logic [1:0] o_cmd_cnt,
  input  logic       i_cmd_ready,
  input  logic       i_cmd_done,
  output logic       o_bus_at,
  output logic [1:0] o_wait_b1,
  output logic [1:0] o_wait_b2,
  output logic [1:0] o_load,
  output logic       o_drop,
  output logic [7:0] o_trips,
  output logic       o_busy,
  output logic       o_fault
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned WDOG_W = 4;
  localparam int unsigned TRIP_W = 8;

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WAIT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_TICKS - 1);
  localparam logic [OP_W-1:0]   OP_BOARD  = OP_W'(0);
  localparam logic [OP_W-1:0]   OP_UP     = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_DOWN   = OP_W'(2);
  localparam logic [OP_W-1:0]   OP_ALIGHT = OP_W'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_BOARD_REQ, S_BOARD_WAIT, S_DRIVE_REQ,
    S_DRIVE_WAIT, S_ALIGHT_REQ, S_ALIGHT_WAIT, S_FAULT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_cmd_valid, w_cmd_valid_nxt;
  logic [OP_W-1:0]     r_cmd_op, w_cmd_op_nxt;
  logic [CNT_W-1:0]    r_cmd_cnt, w_cmd_cnt_nxt;
  logic                r_bus_at, w_bus_at_nxt;
  logic [CNT_W-1:0]    r_wait_b1, w_wait_b1_nxt;
  logic [CNT_W-1:0]    r_wait_b2, w_wait_b2_nxt;
  logic [CNT_W-1:0]    r_load, w_load_nxt;
  logic                r_drop, w_drop_nxt;
  logic [TRIP_W-1:0]   r_trips, w_trips_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_fault, w_fault_nxt;
  logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;

  logic                w_xfer, w_in_wait, w_timeout;
  logic [CNT_W-1:0]    w_wait_here, w_wait_there;
  logic [CNT_W-1:0]    w_sub_b1, w_sub_b2, w_base_b1, w_base_b2;
  logic                w_acc_b1, w_acc_b2;

  assign w_xfer       = r_cmd_valid & i_cmd_ready;
  assign w_in_wait    = (r_state == S_BOARD_WAIT) | (r_state == S_DRIVE_WAIT) |
                        (r_state == S_ALIGHT_WAIT);
  assign w_timeout    = w_in_wait & ~i_cmd_done & i_step_tick & (r_wdog == WDOG_LAST);
  assign w_wait_here  = r_bus_at ? r_wait_b2 : r_wait_b1;
  assign w_wait_there = r_bus_at ? r_wait_b1 : r_wait_b2;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: a done pulse beats a watchdog expiry in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_wait_here != '0)       w_state_nxt = S_BOARD_REQ;
        else if (w_wait_there != '0) w_state_nxt = S_DRIVE_REQ;
      end
      S_BOARD_REQ:  if (w_xfer) w_state_nxt = S_BOARD_WAIT;
      S_BOARD_WAIT: begin
        if (i_cmd_done)     w_state_nxt = S_DRIVE_REQ;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_DRIVE_REQ:  if (w_xfer) w_state_nxt = S_DRIVE_WAIT;
      S_DRIVE_WAIT: begin
        if (i_cmd_done)     w_state_nxt = (r_load != '0) ? S_ALIGHT_REQ : S_IDLE;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_ALIGHT_REQ: if (w_xfer) w_state_nxt = S_ALIGHT_WAIT;
      S_ALIGHT_WAIT: begin
        if (i_cmd_done)     w_state_nxt = S_IDLE;
        else if (w_timeout) w_state_nxt = S_FAULT;
      end
      S_FAULT:      w_state_nxt = S_FAULT;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; command fields latch only on entry to a REQ state
  always_comb begin
    w_cmd_valid_nxt = (w_state_nxt == S_BOARD_REQ) | (w_state_nxt == S_DRIVE_REQ) |
                      (w_state_nxt == S_ALIGHT_REQ);
    w_cmd_op_nxt    = r_cmd_op;
    w_cmd_cnt_nxt   = r_cmd_cnt;
    w_bus_at_nxt    = r_bus_at;
    w_load_nxt      = r_load;
    w_trips_nxt     = r_trips;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_fault_nxt     = (w_state_nxt == S_FAULT);
    w_wdog_nxt      = r_wdog;
    w_sub_b1        = '0;
    w_sub_b2        = '0;

    if (w_state_nxt != r_state) begin
      unique case (w_state_nxt)
        S_BOARD_REQ: begin
          w_cmd_op_nxt  = OP_BOARD;
          w_cmd_cnt_nxt = w_wait_here;
        end
        S_DRIVE_REQ: begin
          w_cmd_op_nxt  = r_bus_at ? OP_DOWN : OP_UP;
          w_cmd_cnt_nxt = '0;
        end
        S_ALIGHT_REQ: begin
          w_cmd_op_nxt  = OP_ALIGHT;
          w_cmd_cnt_nxt = r_load;
        end
        default: ;
      endcase
    end

    if (w_xfer && (r_state == S_BOARD_REQ)) begin
      w_load_nxt = r_cmd_cnt;
      if (r_bus_at) w_sub_b2 = r_cmd_cnt;
      else          w_sub_b1 = r_cmd_cnt;
    end
    if ((r_state == S_DRIVE_WAIT) && i_cmd_done) begin
      w_bus_at_nxt = ~r_bus_at;
      w_trips_nxt  = r_trips + TRIP_W'(1);
    end
    if ((r_state == S_ALIGHT_WAIT) && i_cmd_done) w_load_nxt = '0;

    if (w_xfer)                        w_wdog_nxt = '0;
    else if (w_in_wait && i_step_tick) w_wdog_nxt = r_wdog + WDOG_W'(1);

    // Boarded passengers leave the queue before this cycle's arrival is judged
    w_base_b1     = r_wait_b1 - w_sub_b1;
    w_base_b2     = r_wait_b2 - w_sub_b2;
    w_acc_b1      = i_arrive_b1 & (w_base_b1 < MAX_CNT);
    w_acc_b2      = i_arrive_b2 & (w_base_b2 < MAX_CNT);
    w_wait_b1_nxt = w_base_b1 + CNT_W'(w_acc_b1);
    w_wait_b2_nxt = w_base_b2 + CNT_W'(w_acc_b2);
    w_drop_nxt    = (i_arrive_b1 & ~w_acc_b1) | (i_arrive_b2 & ~w_acc_b2);
  end

  // Registered outputs and datapath state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_cnt   <= '0;
      r_bus_at    <= 1'b0;
      r_wait_b1   <= '0;
      r_wait_b2   <= '0;
      r_load      <= '0;
      r_drop      <= 1'b0;
      r_trips     <= '0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_op    <= w_cmd_op_nxt;
      r_cmd_cnt   <= w_cmd_cnt_nxt;
      r_bus_at    <= w_bus_at_nxt;
      r_wait_b1   <= w_wait_b1_nxt;
      r_wait_b2   <= w_wait_b2_nxt;
      r_load      <= w_load_nxt;
      r_drop      <= w_drop_nxt;
      r_trips     <= w_trips_nxt;
      r_busy      <= w_busy_nxt;
      r_fault     <= w_fault_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  assign o_cmd_valid = r_cmd_valid;
  assign o_cmd_op    = r_cmd_op;
  assign o_cmd_cnt   = r_cmd_cnt;
  assign o_bus_at    = r_bus_at;
  assign o_wait_b1   = r_wait_b1;
  assign o_wait_b2   = r_wait_b2;
  assign o_load      = r_load;
  assign o_drop      = r_drop;
  assign o_trips     = r_trips;
  assign o_busy      = r_busy;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_shuttle_scheduler.sv
// Bench for shuttle_scheduler: trip-plan reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic with random resets.
module tb_shuttle_scheduler;

  localparam int MAX_WAIT      = 2;
  localparam int TIMEOUT_TICKS = 12;
  localparam int D_NEXT = 0, D_RAND = 1, D_HOLD = 2, D_FINAL = 3, D_FORCE = 4;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_step_tick = 1'b0, i_arrive_b1 = 1'b0, i_arrive_b2 = 1'b0;
  logic       i_cmd_ready = 1'b0, i_cmd_done = 1'b0;
  logic       o_cmd_valid, o_bus_at, o_drop, o_busy, o_fault;
  logic [1:0] o_cmd_op, o_cmd_cnt, o_wait_b1, o_wait_b2, o_load;
  logic [7:0] o_trips;

  int checks = 0, failures = 0, n_drop = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0, done_mode = D_NEXT, tick_mode = 0, done_pct = 35;

  // Trip-level reference model
  int m_w1 = 0, m_w2 = 0, m_load = 0, m_bus = 0, m_trips = 0, m_ticks = 0;
  bit m_drop = 0, m_fault = 0, m_idle = 1, m_out = 0;
  int m_plan_op[$], m_plan_cnt[$];
  logic [3:0] cmd_log[$];

  shuttle_scheduler #(.MAX_WAIT(MAX_WAIT), .TIMEOUT_TICKS(TIMEOUT_TICKS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_step_tick(i_step_tick),
    .i_arrive_b1(i_arrive_b1), .i_arrive_b2(i_arrive_b2),
    .o_cmd_valid(o_cmd_valid), .o_cmd_op(o_cmd_op), .o_cmd_cnt(o_cmd_cnt),
    .i_cmd_ready(i_cmd_ready), .i_cmd_done(i_cmd_done),
    .o_bus_at(o_bus_at), .o_wait_b1(o_wait_b1), .o_wait_b2(o_wait_b2),
    .o_load(o_load), .o_drop(o_drop), .o_trips(o_trips),
    .o_busy(o_busy), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model update: plan a whole trip when idle, then retire it command by command
  always @(posedge clk) begin
    int sub1, sub2, here, there, op, cnt, b1, b2;
    bit nd;
    sub1 = 0; sub2 = 0; nd = 0;
    if (i_rst) begin
      m_w1 = 0; m_w2 = 0; m_load = 0; m_bus = 0; m_trips = 0; m_ticks = 0;
      m_drop = 0; m_fault = 0; m_idle = 1; m_out = 0;
      m_plan_op.delete(); m_plan_cnt.delete();
    end else begin
      if (!m_fault) begin
        if (m_idle) begin
          here  = m_bus ? m_w2 : m_w1;
          there = m_bus ? m_w1 : m_w2;
          if (here > 0) begin
            m_plan_op.push_back(0);               m_plan_cnt.push_back(here);
            m_plan_op.push_back(m_bus ? 2 : 1);   m_plan_cnt.push_back(0);
            m_plan_op.push_back(3);               m_plan_cnt.push_back(here);
            m_idle = 0;
          end else if (there > 0) begin
            m_plan_op.push_back(m_bus ? 2 : 1);   m_plan_cnt.push_back(0);
            m_idle = 0;
          end
        end else if (!m_out) begin
          if (i_cmd_ready) begin
            m_out = 1; m_ticks = 0;
            if (m_plan_op[0] == 0) begin
              if (m_bus != 0) sub2 = m_plan_cnt[0];
              else            sub1 = m_plan_cnt[0];
              m_load = m_plan_cnt[0];
            end
          end
        end else if (i_cmd_done) begin
          op  = m_plan_op.pop_front();
          cnt = m_plan_cnt.pop_front();
          m_out = 0;
          if (op == 1 || op == 2) begin m_bus = 1 - m_bus; m_trips = (m_trips + 1) % 256; end
          if (op == 3 && cnt > 0) m_load = 0;
          if (m_plan_op.size() == 0) m_idle = 1;
        end else if (i_step_tick) begin
          m_ticks++;
          if (m_ticks == TIMEOUT_TICKS) begin m_fault = 1; m_out = 0; end
        end
      end
      b1 = m_w1 - sub1;
      b2 = m_w2 - sub2;
      if (i_arrive_b1) begin if (b1 < MAX_WAIT) b1++; else nd = 1; end
      if (i_arrive_b2) begin if (b2 < MAX_WAIT) b2++; else nd = 1; end
      m_w1 = b1; m_w2 = b2; m_drop = nd;
    end
  end

  // Log of accepted commands as {op, cnt}
  always @(posedge clk) begin
    if (i_rst) cmd_log.delete();
    else if (o_cmd_valid && i_cmd_ready) cmd_log.push_back({o_cmd_op, o_cmd_cnt});
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = !m_idle && !m_out && !m_fault;
      chk("cmd_valid", o_cmd_valid, ev);
      if (ev && m_plan_op.size() > 0) begin
        chk("cmd_op", o_cmd_op, m_plan_op[0]);
        chk("cmd_cnt", o_cmd_cnt, m_plan_cnt[0]);
      end
      chk("bus_at", o_bus_at, m_bus);
      chk("wait_b1", o_wait_b1, m_w1);
      chk("wait_b2", o_wait_b2, m_w2);
      chk("load", o_load, m_load);
      chk("drop", o_drop, m_drop);
      chk("trips", o_trips, m_trips);
      chk("busy", o_busy, !m_idle);
      chk("fault", o_fault, m_fault);
      if (o_drop) n_drop++;
    end
  end

  task automatic cyc(input bit a1, input bit a2);
    @(posedge clk); #1;
    i_arrive_b1 = a1;
    i_arrive_b2 = a2;
    case (rdy_mode)
      0:       i_cmd_ready = 1'b1;
      1:       i_cmd_ready = ($urandom_range(0, 99) < 70);
      default: i_cmd_ready = 1'b0;
    endcase
    case (tick_mode)
      0:       i_step_tick = 1'b0;
      1:       i_step_tick = 1'b1;
      default: i_step_tick = ($urandom_range(0, 3) == 0);
    endcase
    case (done_mode)
      D_NEXT:  i_cmd_done = m_out;
      D_RAND:  i_cmd_done = m_out ? ($urandom_range(0, 99) < done_pct)
                                  : ($urandom_range(0, 15) == 0);
      D_FINAL: i_cmd_done = m_out && (m_ticks == TIMEOUT_TICKS - 1);
      D_FORCE: i_cmd_done = 1'b1;
      default: i_cmd_done = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
    i_rst = 1'b0;
  endtask

  task automatic run_quiet(input int lim, input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < lim; k++) begin
      if (m_idle && m_w1 == 0 && m_w2 == 0) begin ok = 1; break; end
      cyc(0, 0);
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, seen, inj;
    logic [3:0] exp_log [11];
    exp_log = '{4'h4, 4'h1, 4'h8, 4'hD, 4'h2, 4'h4, 4'hE, 4'h8, 4'h1, 4'h4, 4'hD};

    @(posedge clk); #1;
    chk_en = 1'b1;

    // Reset held during traffic
    rdy_mode = 1; done_mode = D_RAND; tick_mode = 2;
    for (int k = 0; k < 4; k++) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    cyc(0, 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_wait_b1", o_wait_b1, 0);
    chk("rst_wait_b2", o_wait_b2, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_trips", o_trips, 0);

    // Saturation, snapshot and backpressure
    n_drop = 0; rdy_mode = 2; done_mode = D_NEXT; tick_mode = 0;
    cyc(1, 0); cyc(1, 0); cyc(1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0);
    @(negedge clk);
    chk("sat_wait_b1", o_wait_b1, 2);
    chk("sat_drops", n_drop, 1);
    chk("stall_valid", o_cmd_valid, 1);
    chk("stall_op", o_cmd_op, 0);
    chk("stall_cnt", o_cmd_cnt, 1);
    rdy_mode = 0;
    cyc(0, 0); cyc(0, 0);
    @(negedge clk);
    chk("snap_wait_b1", o_wait_b1, 1);
    chk("snap_load", o_load, 1);
    run_quiet(200, "quiet_snapshot");

    // Empty run to B2, then trips both ways incl. arrival in a BOARD/2 transfer cycle
    do_reset();
    done_mode = D_HOLD;
    cyc(0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0);
    cyc(1, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);
    done_mode = D_NEXT;
    ok = 0; seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (m_idle && m_w1 == 0 && m_w2 == 0) begin ok = 1; break; end
      inj = !seen && !m_idle && !m_out && m_plan_op.size() > 0 &&
            m_plan_op[0] == 0 && m_plan_cnt[0] == 2;
      cyc(inj, 0);
      if (inj) begin
        seen = 1;
        cyc(0, 0);
        @(negedge clk);
        chk("xfer_arr_wait_b1", o_wait_b1, 1);
        chk("xfer_arr_load", o_load, 2);
      end
    end
    chk("trip_quiet", ok, 1);
    chk("xfer_arr_seen", seen, 1);
    @(negedge clk);
    chk("log_len", cmd_log.size(), 11);
    for (int k = 0; k < 11 && k < cmd_log.size(); k++) chk($sformatf("log_%0d", k), cmd_log[k], exp_log[k]);
    chk("trip_bus_at", o_bus_at, 1);
    chk("trip_trips", o_trips, 5);
    chk("trip_load", o_load, 0);

    // Watchdog expiry in DRIVE_WAIT
    do_reset();
    tick_mode = 1; done_mode = D_NEXT;
    cyc(1, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(0, 0);
      if (m_out && m_plan_op.size() > 0 && m_plan_op[0] == 1) begin
        i_cmd_done = 1'b0; done_mode = D_HOLD; break;
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (m_fault) break;
      cyc(0, 0);
    end
    @(negedge clk);
    chk("wd_fault", o_fault, 1);
    chk("wd_valid", o_cmd_valid, 0);
    chk("wd_busy", o_busy, 1);
    done_mode = D_FORCE;
    cyc(0, 0); cyc(1, 0); cyc(0, 0);
    @(negedge clk);
    chk("late_fault", o_fault, 1);
    chk("late_trips", o_trips, 0);
    chk("late_bus_at", o_bus_at, 0);
    chk("late_load", o_load, 1);
    chk("fault_arrival", o_wait_b1, 1);

    // Done on the final tick of every wait: no fault
    do_reset();
    tick_mode = 1; done_mode = D_FINAL;
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
    run_quiet(300, "quiet_final_tick");
    @(negedge clk);
    chk("final_tick_fault", o_fault, 0);
    chk("final_tick_trips", o_trips, 1);
    chk("final_tick_bus", o_bus_at, 1);

    // Randomized traffic
    do_reset();
    rdy_mode = 1; done_mode = D_RAND; tick_mode = 2;
    for (int seg = 0; seg < 15; seg++) begin
      done_pct = (seg % 3 == 2) ? 3 : 35;
      for (int k = 0; k < 200; k++) begin
        cyc($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        i_rst = ($urandom_range(0, 249) == 0);
      end
    end
    i_rst = 1'b0;
    cyc(0, 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
